// File: rtl/m_pkg.sv
`default_nettype none
// ============================================================================
// Module   : m_pkg
// Purpose  : Shared types and widths for the signed 8x8 radix-4 Booth
//            multiplier datapath (reduction stages and final CPA).
// Revision : 1.0 - initial release
// ============================================================================
package m_pkg;

    localparam int unsigned PROD_W    = 16;
    localparam int unsigned CPA_SPLIT = 8;

    typedef logic [PROD_W-1:0] prod_t;

    // Carry-save pair; the carry vector is already aligned to its weight.
    typedef struct packed {
        prod_t sum;
        prod_t carry;
    } cs_pair_t;

endpackage : m_pkg
`default_nettype wire

// File: rtl/m_final_cpa_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : m_final_cpa_pipe_if
// Purpose  : Carry-save input channel and product output channel of the
//            final CPA pipe, each with a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
interface m_final_cpa_pipe_if #(
    parameter int unsigned WIDTH = m_pkg::PROD_W
);
    logic [WIDTH-1:0] in_sum;
    logic [WIDTH-1:0] in_carry;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_product;
    logic             out_valid;
    logic             out_ready;

    // Producer of carry-save pairs and consumer of products.
    modport master (
        output in_sum, in_carry, in_valid, out_ready,
        input  in_ready, out_product, out_valid
    );

    // The pipe itself.
    modport slave (
        input  in_sum, in_carry, in_valid, out_ready,
        output in_ready, out_product, out_valid
    );
endinterface : m_final_cpa_pipe_if
`default_nettype wire

// File: rtl/m_cpa_slice.sv
`default_nettype none
// ============================================================================
// Module   : m_cpa_slice
// Purpose  : N-bit ripple-carry adder slice built from m_fa cells; one slice
//            per pipeline stage of the final CPA.
// Revision : 1.0 - initial release
// ============================================================================
module m_cpa_slice #(
    parameter int unsigned N         = 8,
    parameter int unsigned NAND_TIME = 7
) (
    input  wire logic [N-1:0] a,
    input  wire logic [N-1:0] b,
    input  wire logic         cin,
    output logic      [N-1:0] s,
    output logic              cout
);

    logic [N:0] w_c;

    assign w_c[0] = cin;
    assign cout   = w_c[N];

    // Ripple chain: carry of bit i feeds bit i+1.
    for (genvar i = 0; i < N; i++) begin : g_bit
        m_fa #(.NAND_TIME(NAND_TIME)) u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (w_c[i]),
            .s    (s[i]),
            .cout (w_c[i+1])
        );
    end

endmodule : m_cpa_slice
`default_nettype wire

// File: rtl/m_fa.sv
`default_nettype none
// ============================================================================
// Module   : m_fa
// Purpose  : One-bit full adder cell. A positive NAND_TIME selects the
//            nine-NAND form used for gate-delay simulation; both forms
//            compute the same function.
// Revision : 1.0 - initial release
// ============================================================================
module m_fa #(
    parameter int unsigned NAND_TIME = 7
) (
    input  wire logic a,
    input  wire logic b,
    input  wire logic cin,
    output logic      s,
    output logic      cout
);

    if (NAND_TIME > 0) begin : g_nand
        logic w_n1, w_n2, w_n3, w_x1, w_n4, w_n5, w_n6;
        // Classic nine-NAND full adder.
        assign w_n1 = ~(a & b);
        assign w_n2 = ~(a & w_n1);
        assign w_n3 = ~(b & w_n1);
        assign w_x1 = ~(w_n2 & w_n3);
        assign w_n4 = ~(w_x1 & cin);
        assign w_n5 = ~(w_x1 & w_n4);
        assign w_n6 = ~(cin & w_n4);
        assign s    = ~(w_n5 & w_n6);
        assign cout = ~(w_n4 & w_n1);
    end else begin : g_logic
        assign s    = a ^ b ^ cin;
        assign cout = (a & b) | (cin & (a ^ b));
    end

endmodule : m_fa
`default_nettype wire

// File: rtl/m_final_cpa_pipe.sv
`default_nettype none
// ============================================================================
// Module   : m_final_cpa_pipe
// Purpose  : Final stage of the Booth multiplier. Resolves the carry-save
//            pair into a product with a two-stage pipelined CPA (low slice
//            in stage A, high slice in stage B), valid/ready on both sides,
//            and a wrapping count of delivered products.
// Revision : 1.0 - initial release
// ============================================================================
module m_final_cpa_pipe
    import m_pkg::*;
#(
    parameter int unsigned NAND_TIME = 7,
    parameter int unsigned WIDTH     = PROD_W,
    parameter int unsigned SPLIT     = CPA_SPLIT
) (
    input  wire logic         clk,
    input  wire logic         rst,
    m_final_cpa_pipe_if.slave bus,
    output logic [7:0]        done_count
);

    localparam int unsigned HI_W = WIDTH - SPLIT;

    logic             w_lda;
    logic             w_ldb;
    logic [SPLIT-1:0] w_lo_sum;
    logic             w_lo_cout;
    logic [HI_W-1:0]  w_hi_sum;
    logic             w_unused_hi_cout;   // carry out of the MSB is discarded

    logic             r_va;
    logic [SPLIT-1:0] r_lo_a;
    logic             r_ca;
    logic [HI_W-1:0]  r_hi_sum;
    logic [HI_W-1:0]  r_hi_carry;

    logic             r_vb;
    logic [WIDTH-1:0] r_product;
    logic [7:0]       r_done_count;

    // No skid buffer: A can take new data only if empty or draining into B.
    assign w_ldb        = r_va && (!r_vb || bus.out_ready);
    assign bus.in_ready = !r_va || w_ldb;
    assign w_lda        = bus.in_valid && bus.in_ready;

    assign bus.out_valid   = r_vb;
    assign bus.out_product = r_product;
    assign done_count      = r_done_count;

    m_cpa_slice #(.N(SPLIT), .NAND_TIME(NAND_TIME)) u_slice_lo (
        .a    (bus.in_sum[SPLIT-1:0]),
        .b    (bus.in_carry[SPLIT-1:0]),
        .cin  (1'b0),
        .s    (w_lo_sum),
        .cout (w_lo_cout)
    );

    m_cpa_slice #(.N(HI_W), .NAND_TIME(NAND_TIME)) u_slice_hi (
        .a    (r_hi_sum),
        .b    (r_hi_carry),
        .cin  (r_ca),
        .s    (w_hi_sum),
        .cout (w_unused_hi_cout)
    );

    // Stage A: low-slice result, its carry, and the untouched upper halves.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_va       <= 1'b0;
            r_lo_a     <= '0;
            r_ca       <= 1'b0;
            r_hi_sum   <= '0;
            r_hi_carry <= '0;
        end else if (w_lda) begin
            r_va       <= 1'b1;
            r_lo_a     <= w_lo_sum;
            r_ca       <= w_lo_cout;
            r_hi_sum   <= bus.in_sum[WIDTH-1:SPLIT];
            r_hi_carry <= bus.in_carry[WIDTH-1:SPLIT];
        end else if (w_ldb) begin
            r_va       <= 1'b0;
        end
    end

    // Stage B: completes the high slice and holds the product until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vb      <= 1'b0;
            r_product <= '0;
        end else if (w_ldb) begin
            r_vb      <= 1'b1;
            r_product <= {w_hi_sum, r_lo_a};
        end else if (bus.out_ready) begin
            r_vb      <= 1'b0;
        end
    end

    // Delivered-product counter, wraps modulo 256.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_count <= 8'd0;
        end else if (r_vb && bus.out_ready) begin
            r_done_count <= r_done_count + 8'd1;
        end
    end

endmodule : m_final_cpa_pipe
`default_nettype wire

// File: tb/tb_m_final_cpa_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_m_final_cpa_pipe
// Purpose  : Self-checking bench for m_final_cpa_pipe. The driver pushes the
//            hand-computed product of each accepted pair into a queue; a
//            monitor pops and compares on every output transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_m_final_cpa_pipe;
    import m_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] done_count;

    always #5 clk = ~clk;

    m_final_cpa_pipe_if #(.WIDTH(PROD_W)) bus ();

    m_final_cpa_pipe #(
        .NAND_TIME (7),
        .WIDTH     (PROD_W),
        .SPLIT     (CPA_SPLIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .done_count (done_count)
    );

    int         n_checks    = 0;
    int         n_fail      = 0;
    int         cyc         = 0;
    int         n_accepted  = 0;
    int         n_delivered = 0;
    logic [7:0] mdl_done    = 8'd0;
    prod_t      exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send(input cs_pair_t v, input prod_t exp, output int fire_cyc);
        bus.in_sum   = v.sum;
        bus.in_carry = v.carry;
        bus.in_valid = 1'b1;
        fire_cyc     = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                fire_cyc = cyc;
                exp_q.push_back(exp);
                n_accepted++;
                break;
            end
        end
        if (fire_cyc < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready never rose for sum 0x%0h", v.sum);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.out_valid) break;
        end
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: compares every delivered product and the count before it.
    logic  hold_pending = 1'b0;
    prod_t held;
    always @(negedge clk) begin
        if (rst) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("stall_hold_valid", bus.out_valid, 1);
                check("stall_hold_data", bus.out_product, held);
            end
            if (bus.out_valid && bus.out_ready) begin
                check("done_count_step", done_count, mdl_done);
                if (exp_q.size() == 0) begin
                    check("unexpected_product", bus.out_product, 32'hDEAD_BEEF);
                end else begin
                    check("product", bus.out_product, exp_q.pop_front());
                end
                mdl_done = mdl_done + 8'd1;
                n_delivered++;
            end
            hold_pending = bus.out_valid && !bus.out_ready;
            held         = bus.out_product;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int         fc;
        int         lat;
        int         del0;
        logic [7:0] dc0;
        logic [7:0] dc1;

        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_sum      = '0;
        bus.in_carry    = '0;
        bus.out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_product", bus.out_product, 0);
        check("rst_done_count", done_count, 0);
        check("rst_in_ready", bus.in_ready, 1);

        // Carry crossing the split, with latency measurement
        @(posedge clk); #1;
        send('{sum: 16'h00FF, carry: 16'h0001}, 16'h0100, fc);
        lat = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = cyc - fc;
                break;
            end
        end
        check("latency", lat, 2);
        drain("drain_t1");

        // Top carry discarded; Booth -3 x 4 = -12
        @(posedge clk); #1;
        send('{sum: 16'hFFFF, carry: 16'h0001}, 16'h0000, fc);
        send('{sum: 16'hFFF0, carry: 16'h0004}, 16'hFFF4, fc);
        drain("drain_t2");

        // Back-to-back stream against a 3-cycle output stall
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_accepted    = 0;
        del0          = n_delivered;
        fork
            begin
                send('{sum: 16'h0001, carry: 16'h0001}, 16'h0002, fc);
                send('{sum: 16'h0010, carry: 16'h0010}, 16'h0020, fc);
                send('{sum: 16'h0100, carry: 16'h0100}, 16'h0200, fc);
                send('{sum: 16'h1000, carry: 16'h1000}, 16'h2000, fc);
            end
            begin
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                check("stall_first_product", bus.out_product, 16'h0002);
                @(posedge clk);
                #1;
                check("stall_in_ready_low", bus.in_ready, 0);
                check("stall_accepts", n_accepted, 2);
                check("stall_out_valid", bus.out_valid, 1);
                check("stall_product_held", bus.out_product, 16'h0002);
                bus.out_ready = 1'b1;
            end
        join
        drain("drain_stream");
        check("stream_delivered", n_delivered - del0, 4);

        // Deliver + advance + accept on one edge
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send('{sum: 16'h0003, carry: 16'h0004}, 16'h0007, fc);
        send('{sum: 16'h0030, carry: 16'h0040}, 16'h0070, fc);
        check("both_full_in_ready", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        bus.in_sum    = 16'h0300;
        bus.in_carry  = 16'h0400;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        check("simul_in_ready", bus.in_ready, 1);
        dc0 = done_count;
        dc1 = dc0 + 8'd1;
        exp_q.push_back(16'h0700);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("simul_done_plus1", done_count, dc1);
        check("simul_out_valid", bus.out_valid, 1);
        drain("drain_simul");

        // Reset while both stages hold data
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send('{sum: 16'h1111, carry: 16'h1111}, 16'h2222, fc);
        send('{sum: 16'h0101, carry: 16'h0202}, 16'h0303, fc);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        mdl_done = 8'd0;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_out_product", bus.out_product, 0);
        check("midrst_done_count", done_count, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("midrst_no_ghost", bus.out_valid, 0);
        end

        // 256 unstalled transactions: done_count wraps back to 0
        @(posedge clk); #1;
        del0 = n_delivered;
        for (int i = 0; i < 256; i++) begin
            send('{sum: 16'(i), carry: 16'h00FF}, 16'(i + 255), fc);
        end
        drain("drain_wrap");
        check("wrap_delivered", n_delivered - del0, 256);
        check("wrap_done_count", done_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_m_final_cpa_pipe
`default_nettype wire

// File: doc/m_final_cpa_pipe.md
Name: m_final_cpa_pipe

Overview:
- Final stage of the signed 8x8 radix-4 Booth multiplier.
- Consumes the carry-save pair (sum vector, carry vector) left by the last reduction stage and resolves it with a two-stage pipelined carry-propagate adder into a 16-bit product.
- Carries a valid/ready handshake on both sides so the multiplier can stall against its consumer.
- Keeps a wrapping count of delivered products for bring-up and debug.

Parameters:
- NAND_TIME, 7ns, per-gate delay applied inside the adder cells (simulation only).
- WIDTH, 16, product and carry-save vector width.
- SPLIT, 8, bit position where the adder is cut between pipeline stages A and B; 1 <= SPLIT < WIDTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_sum  input  WIDTH  sum vector from the final reduction stage.
- in_carry  input  WIDTH  carry vector, already aligned to weight (no further shift here).
- in_valid  input  1  in_sum/in_carry hold a transaction.
- in_ready  output  1  block accepts the transaction this cycle.
- out_product  output  WIDTH  two's-complement product.
- out_valid  output  1  out_product holds a result.
- out_ready  input  1  consumer accepts out_product this cycle.
- done_count  output  8  number of products delivered, modulo 256.

Behaviour:
- Handshake: a transfer occurs on a rising edge where valid && ready. Inputs are sampled only on input transfers.
- Stage A holds vA, lo_A (the SPLIT-bit sum of the low slices), c_A (carry out of the low slice), and the upper WIDTH-SPLIT bits of sum and carry.
  - Loads when ldA = in_valid && in_ready.
  - Otherwise keeps its data while it is stalled.
- Stage B holds vB and the full product register.
  - Upper bits = hi_sum + hi_carry + c_A, with the carry out of bit WIDTH-1 discarded.
  - Lower bits = lo_A.
  - Loads when ldB = vA && (!vB || out_ready).
- Control equations:
  - in_ready = !vA || ldB, which is combinational from out_ready (no skid buffer).
  - vA_next = ldA ? 1 : (ldB ? 0 : vA).
  - vB_next = ldB ? 1 : ((out_ready && vB) ? 0 : vB).
- Outputs: out_valid = vB; out_product = stage B register.
- Latency is exactly 2 cycles from the input transfer edge to out_valid when unstalled. Throughput is 1 product per cycle.
- Stall behaviour:
  - While out_valid && !out_ready, out_product and out_valid hold unchanged.
  - Stage A fills; in_ready then goes low.
  - Products are never dropped, duplicated or reordered.
- Simultaneous events: with both stages full and out_ready=1, B delivers, A moves to B and a new input enters A, all on the same edge.
- done_count increments on every out_valid && out_ready edge and wraps 255 -> 0.
- Reset (rst=1 at any edge, including mid-operation): vA=vB=0, product and stage A data registers=0, done_count=0, so out_valid=0 and out_product=0.
  - In-flight transactions are discarded.
  - in_ready is 1 in the first cycle after reset, when out_ready is irrelevant.
- Arithmetic: modulo 2^WIDTH. Sign comes from the Booth correction bits already in the vectors; no sign extension is done here.

Decomposition:
- Package m_pkg holds:
  - PROD_W=16 and CPA_SPLIT=8;
  - typedef logic [PROD_W-1:0] prod_t;
  - typedef struct {sum, carry} cs_pair_t, used by the reduction stages and this block.
- One sub-module, m_cpa_slice: an N-bit ripple adder (a, b, cin -> s, cout) built from the existing FA cell with NAND_TIME passed through. It is instantiated once per pipeline stage.
- Registers and handshake logic stay in the top level.

Test Plan:
- in_sum=0x00FF, in_carry=0x0001, out_ready=1 -> out_product=0x0100 with out_valid exactly 2 cycles after the transfer (carry crosses SPLIT).
- in_sum=0xFFFF, in_carry=0x0001 -> out_product=0x0000 (top carry discarded); then sum=0xFFF0, carry=0x0004 -> 0xFFF4, i.e. -12 from Booth -3 x 4.
- Stream of 4 back-to-back transfers (0x0001+0x0001, 0x0010+0x0010, 0x0100+0x0100, 0x1000+0x1000) with out_ready held 0 for 3 cycles. Required:
  - in_ready falls after 2 accepts;
  - out_product holds 0x0002 while stalled;
  - outputs then appear in order 0x0002, 0x0020, 0x0200, 0x2000 with none lost.
- Both stages valid and out_ready=1 with new in_valid -> a deliver, an advance and an accept occur on the same edge, and done_count increments by exactly 1.
- rst asserted for 1 cycle while both stages are valid -> next cycle out_valid=0, out_product=0x0000, done_count=0, in_ready=1; the discarded products never appear.
- 256 unstalled transactions -> done_count steps 0..255 and then wraps to 0.
